// File: rtl/sccb_responder.sv
// SCCB target with a 256x8 register file, used as an in-FPGA camera model.
// Optional COM7 soft reset enabled by defining SCCB_RESP_SOFT_RESET_EN.
module sccb_responder #(
  parameter int unsigned IN_FREQ    = 50_000_000,
  parameter logic [7:0]  DEV_ID     = 8'h42,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sioc_i,
  input  logic       siod_i,
  output logic       siod_oe_o,
  output logic       wr_stb_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  input  logic [7:0] host_addr_i,
  output logic [7:0] host_data_o,
  output logic       busy_o
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  if (IN_FREQ == 0 || FILTER_LEN == 0) begin : g_bad_cfg
    $error("sccb_responder: IN_FREQ and FILTER_LEN must be non-zero");
  end

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ID        = 4'd1;
  localparam logic [3:0] S_ID_ACK    = 4'd2;
  localparam logic [3:0] S_SUB       = 4'd3;
  localparam logic [3:0] S_SUB_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RD_NA     = 4'd8;
  localparam logic [3:0] S_IGNORE    = 4'd9;

  // Bit 0 = SIOC, bit 1 = SIOD. Bus idles high, so the input path resets high.
  logic [1:0]          s1_q, s1_d, s2_q, s2_d, f_q, f_d, chg;
  logic [1:0][CW-1:0]  fc_q, fc_d;
  logic                sioc_rise, sioc_fall, start_c, stop_c;

  logic [3:0] state_q, state_d, bcnt_q, bcnt_d;
  logic [7:0] sh_q, sh_d, ptr_q, ptr_d, rbyte_q, rbyte_d, byte_in;
  logic       oe_q, oe_d, busy_q, busy_d, rw_q, rw_d;
  logic       wr_stb_q, wr_stb_d, clr;
  logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d, host_data_q, host_data_d;
  logic [7:0] regs_q [256];
  logic [7:0] regs_d [256];

  always_comb begin
    s1_d = {siod_i, sioc_i};
    s2_d = s1_q;
    for (int i = 0; i < 2; i++) begin
      chg[i]  = (s2_q[i] != f_q[i]) && (fc_q[i] == CW'(FILTER_LEN - 1));
      fc_d[i] = (s2_q[i] == f_q[i] || chg[i]) ? '0 : fc_q[i] + CW'(1);
      f_d[i]  = chg[i] ? s2_q[i] : f_q[i];
    end
  end

  assign sioc_rise = chg[0] & ~f_q[0];
  assign sioc_fall = chg[0] &  f_q[0];
  // START/STOP only while SIOC is steadily high.
  assign start_c   = chg[1] &  f_q[1] & f_q[0] & ~chg[0];
  assign stop_c    = chg[1] & ~f_q[1] & f_q[0] & ~chg[0];
  assign byte_in   = {sh_q[6:0], f_q[1]};

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    sh_d      = sh_q;
    ptr_d     = ptr_q;
    rbyte_d   = rbyte_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    rw_d      = rw_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (stop_c) begin
      state_d = S_IDLE;
      bcnt_d  = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_c) begin
      state_d = S_ID;
      bcnt_d  = '0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        S_ID, S_SUB, S_WDATA: if (sioc_rise) begin
          sh_d   = byte_in;
          bcnt_d = bcnt_q + 4'd1;
          if (bcnt_q == 4'd7) begin
            case (state_q)
              S_ID: if (byte_in[7:1] == DEV_ID[7:1]) begin
                state_d = S_ID_ACK;
                busy_d  = 1'b1;
                rw_d    = byte_in[0];
              end else begin
                state_d = S_IGNORE;
              end
              S_SUB: begin
                ptr_d   = byte_in;
                state_d = S_SUB_ACK;
              end
              default: begin
                wr_stb_d  = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = byte_in;
                state_d   = S_WDATA_ACK;
              end
            endcase
          end
        end
        // bcnt=8: drive ACK on the next fall; bcnt=9: ACK clocked, release.
        S_ID_ACK, S_SUB_ACK, S_WDATA_ACK: begin
          if (sioc_rise && bcnt_q == 4'd8) bcnt_d = 4'd9;
          if (sioc_fall && bcnt_q == 4'd8) oe_d = 1'b1;
          if (sioc_fall && bcnt_q == 4'd9) begin
            oe_d   = 1'b0;
            bcnt_d = '0;
            case (state_q)
              S_ID_ACK: if (rw_q) begin
                state_d = S_RDATA;
                rbyte_d = regs_q[ptr_q];
                oe_d    = ~regs_q[ptr_q][7];
              end else begin
                state_d = S_SUB;
              end
              S_SUB_ACK: state_d = S_WDATA;
              default:   state_d = S_IGNORE;
            endcase
          end
        end
        S_RDATA: begin
          if (sioc_rise) bcnt_d = bcnt_q + 4'd1;
          if (sioc_fall) begin
            if (bcnt_q == 4'd8) begin
              oe_d    = 1'b0;
              state_d = S_RD_NA;
            end else begin
              oe_d = ~rbyte_q[3'd7 - bcnt_q[2:0]];
            end
          end
        end
        S_RD_NA:  if (sioc_rise) state_d = S_IGNORE;
        S_IDLE, S_IGNORE: ;
        default:  state_d = S_IDLE;
      endcase
    end
  end

`ifdef SCCB_RESP_SOFT_RESET_EN
  assign clr = wr_stb_q && (wr_addr_q == 8'h12) && wr_data_q[7];
`else
  assign clr = 1'b0;
`endif

  always_comb begin
    regs_d = regs_q;
    if (clr) begin
      for (int i = 0; i < 256; i++) regs_d[i] = '0;
    end else if (wr_stb_d) begin
      regs_d[ptr_q] = byte_in;
    end
    host_data_d = regs_q[host_addr_i];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q        <= 2'b11;
      s2_q        <= 2'b11;
      f_q         <= 2'b11;
      fc_q        <= '0;
      state_q     <= S_IDLE;
      bcnt_q      <= '0;
      sh_q        <= '0;
      ptr_q       <= '0;
      rbyte_q     <= '0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      host_data_q <= '0;
      for (int i = 0; i < 256; i++) regs_q[i] <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      f_q         <= f_d;
      fc_q        <= fc_d;
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      sh_q        <= sh_d;
      ptr_q       <= ptr_d;
      rbyte_q     <= rbyte_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      host_data_q <= host_data_d;
      regs_q      <= regs_d;
    end
  end

  assign siod_oe_o   = oe_q;
  assign busy_o      = busy_q;
  assign wr_stb_o    = wr_stb_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign host_data_o = host_data_q;

endmodule
